// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the load/store unit.
//   * RISC-V funct3 width codes
//   * FSM state enumeration
//   * st_merge(): folds a sub-word store into a read-back memory word
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_RESP
    } lsu_state_e;

    // Replace the addressed byte/half of 'word' with the low bits of 'wdata'.
    // Lanes are little-endian: lane 0 is bits 7:0.
    function automatic logic [31:0] st_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        if (f3 == F3_H)
            r[{off[1], 4'b0000} +: 16] = wdata[15:0];
        else
            r[{off, 3'b000} +: 8] = wdata[7:0];
        return r;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if -- request/response bus between a requester and load_store_unit.
//   req_valid/req_ready handshake, req_we (1=store), req_funct3 width code,
//   req_addr byte address, req_wdata right-justified store data;
//   rsp_valid one-cycle completion pulse, rsp_rdata extended load data,
//   rsp_err rejected request.
// Modports: master = requester, slave = load_store_unit.
interface lsu_if #(parameter int ADDR_W = 8);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/lsu_ld_align.sv
// lsu_ld_align -- combinational load lane select and extension.
//   i_word   : 32-bit memory word
//   i_funct3 : width code (B/H sign-extend, BU/HU zero-extend, W unchanged)
//   i_off    : byte offset; byte lane = i_off, half lane = i_off[1]
//   o_data   : right-justified extended load data
module lsu_ld_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_off, 3'b000} +: 8];
        w_half = i_off[1] ? i_word[31:16] : i_word[15:0];
        o_data = i_word;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_data = {24'h0, w_byte};
            F3_HU:   o_data = {16'h0, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit -- sequences byte/half/word loads and stores onto a
// single-port synchronous word memory (read data one edge after address).
//   i_clk, i_rst    : clock, asynchronous active-high reset
//   bus (lsu_if)    : request/response handshake (slave side)
//   o_mem_addr      : word address, o_mem_data : write word,
//   o_mem_mw        : write enable, i_mem_q : read word
// Sub-word stores are read-modify-write. Define LSU_ALIGN_CHECK_EN to reject
// misaligned H/HU/W accesses; otherwise the misaligned low bits are cleared.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    lsu_if.slave              bus,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_data,
    output logic              o_mem_mw,
    input  logic [31:0]       i_mem_q
);

    lsu_state_e        r_state, w_next;
    logic              r_we, r_err;
    logic [2:0]        r_f3;
    logic [1:0]        r_off;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_data;
    logic              r_rsp_valid, r_rsp_err;
    logic [31:0]       r_rdata;

    logic [2:0]        w_f3;
    logic              w_bad_code, w_misalign, w_err;
    logic [1:0]        w_off;
    logic [31:0]       w_ld_data;

    // ---------------- request decode (used only on the accept edge)
    always_comb begin
        w_f3       = bus.req_funct3;
        // Unsigned widths are load-only.
        w_bad_code = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111) ||
                     (bus.req_we && w_f3[2]);
`ifdef LSU_ALIGN_CHECK_EN
        w_misalign = (((w_f3 == F3_H) || (w_f3 == F3_HU)) && bus.req_addr[0]) ||
                     ((w_f3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
        w_off      = bus.req_addr[1:0];
`else
        w_misalign = 1'b0;
        w_off      = bus.req_addr[1:0];
        if ((w_f3 == F3_H) || (w_f3 == F3_HU)) w_off[0] = 1'b0;
        if (w_f3 == F3_W)                      w_off    = 2'b00;
`endif
        w_err      = w_bad_code || w_misalign;
    end

    // ---------------- FSM
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        bus.req_ready = 1'b0;
        o_mem_mw      = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = !i_rst;
                if (bus.req_valid) begin
                    if (w_err)                                w_next = S_RESP;
                    else if (bus.req_we && (w_f3 == F3_W))    w_next = S_WRITE;
                    else                                      w_next = S_READ;
                end
            end
            S_READ:  w_next = r_we ? S_MERGE : S_RESP;
            S_MERGE: w_next = S_WRITE;
            S_WRITE: begin
                // Decoded from state so reset removes it without waiting for an edge.
                o_mem_mw = 1'b1;
                w_next   = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- datapath
    // Stores and errors carry no data, so their pulse is issued while in RESP.
    // Loads pulse on leaving RESP, once MEM_Q has been captured and extended.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_f3        <= 3'b000;
            r_off       <= 2'b00;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.req_valid) begin
                    r_we  <= bus.req_we;
                    r_f3  <= w_f3;
                    r_off <= w_off;
                    r_err <= w_err;
                    if (w_err) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rdata     <= '0;
                    end else begin
                        r_mem_addr <= bus.req_addr[ADDR_W+1:2];
                        // Sub-word stores keep the store data here until MERGE.
                        r_mem_data <= bus.req_wdata;
                    end
                end
                S_MERGE: r_mem_data <= st_merge(i_mem_q, r_mem_data, r_f3, r_off);
                S_WRITE: begin
                    r_rsp_valid <= 1'b1;
                    r_rdata     <= '0;
                end
                S_RESP: if (!r_we && !r_err) begin
                    r_rsp_valid <= 1'b1;
                    r_rdata     <= w_ld_data;
                end
                default: ;
            endcase
        end
    end

    lsu_ld_align u_ld_align (
        .i_word   (i_mem_q),
        .i_funct3 (r_f3),
        .i_off    (r_off),
        .o_data   (w_ld_data)
    );

    assign o_mem_addr    = r_mem_addr;
    assign o_mem_data    = r_mem_data;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit -- directed self-checking bench for load_store_unit with
// a synchronous word memory model. Honors LSU_ALIGN_CHECK_EN like the RTL.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  mem_addr;
    logic [31:0] mem_data, mem_q;
    logic        mem_mw;
    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    int nchk = 0;
    int nfail = 0;

    lsu_if #(.ADDR_W(8)) bus ();

    load_store_unit #(.ADDR_W(8)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .bus        (bus),
        .o_mem_addr (mem_addr),
        .o_mem_data (mem_data),
        .o_mem_mw   (mem_mw),
        .i_mem_q    (mem_q)
    );

    always #5 clk = ~clk;

    // Read data is poisoned in the cycle after a write.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_mw) mem[mem_addr] <= mem_data;
        mem_q <= mem_mw ? 32'hBAD0_BAD0 : mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issue one request; cycle k = k-th falling edge after the accept edge.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic err, output int mwcnt, output int mwcyc,
                          output logic vld_after);
        lat = -1; rd = '0; err = 1'b0; mwcnt = 0; mwcyc = -1; vld_after = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd;
        chk("ready_before_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_mw) begin
                mwcnt++;
                if (mwcyc < 0) mwcyc = k;
            end
            if (bus.rsp_valid) begin
                lat = k; rd = bus.rsp_rdata; err = bus.rsp_err;
                break;
            end
        end
        @(negedge clk);
        vld_after = bus.rsp_valid;
        if (mem_mw) mwcnt++;
    endtask

    int          lat, mwcnt, mwcyc;
    logic [31:0] rd;
    logic        err, va;

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;

        // reset state
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mw", 32'(mem_mw), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data", mem_data, 32'd0);

        preload(8'd1, 32'h0000_CAFE);
        preload(8'd2, 32'h1122_3344);
        preload(8'd3, 32'h0000_0000);
        preload(8'd5, 32'h8040_20F0);
        @(negedge clk) rst = 1'b0;

        // loads from mem[5] = 8040_20F0
        do_req(1'b0, 3'b000, 10'h16, '0, lat, rd, err, mwcnt, mwcyc, va);
        chk("lb16_data", rd, 32'h0000_0040);
        chk("lb16_lat", 32'(lat), 32'd3);
        chk("lb16_err", 32'(err), 32'd0);
        chk("lb16_pulse_width", 32'(va), 32'd0);
        chk("lb16_no_write", 32'(mwcnt), 32'd0);
        do_req(1'b0, 3'b001, 10'h16, '0, lat, rd, err, mwcnt, mwcyc, va);
        chk("lh16_data", rd, 32'hFFFF_8040);
        do_req(1'b0, 3'b101, 10'h16, '0, lat, rd, err, mwcnt, mwcyc, va);
        chk("lhu16_data", rd, 32'h0000_8040);
        do_req(1'b0, 3'b000, 10'h17, '0, lat, rd, err, mwcnt, mwcyc, va);
        chk("lb17_data", rd, 32'hFFFF_FF80);
        do_req(1'b0, 3'b100, 10'h17, '0, lat, rd, err, mwcnt, mwcyc, va);
        chk("lbu17_data", rd, 32'h0000_0080);
        do_req(1'b0, 3'b000, 10'h14, '0, lat, rd, err, mwcnt, mwcyc, va);
        chk("lb14_data", rd, 32'hFFFF_FFF0);
        do_req(1'b0, 3'b001, 10'h14, '0, lat, rd, err, mwcnt, mwcyc, va);
        chk("lh14_data", rd, 32'h0000_20F0);

        // SB into mem[2] = 1122_3344
        do_req(1'b1, 3'b000, 10'h09, 32'h0000_00AB, lat, rd, err, mwcnt, mwcyc, va);
        chk("sb09_mem", mem[2], 32'h1122_AB44);
        chk("sb09_mw_count", 32'(mwcnt), 32'd1);
        chk("sb09_mw_cycle", 32'(mwcyc), 32'd3);
        chk("sb09_lat", 32'(lat), 32'd4);
        chk("sb09_rdata", rd, 32'd0);
        chk("sb09_pulse_width", 32'(va), 32'd0);

        // SH upper half of mem[2]
        do_req(1'b1, 3'b001, 10'h0A, 32'hFFFF_5566, lat, rd, err, mwcnt, mwcyc, va);
        chk("sh0a_mem", mem[2], 32'h5566_AB44);
        chk("sh0a_mw_count", 32'(mwcnt), 32'd1);

        // SW then LW
        do_req(1'b1, 3'b010, 10'h0C, 32'hDEAD_BEEF, lat, rd, err, mwcnt, mwcyc, va);
        chk("sw0c_mem", mem[3], 32'hDEAD_BEEF);
        chk("sw0c_mw_cycle", 32'(mwcyc), 32'd1);
        chk("sw0c_mw_count", 32'(mwcnt), 32'd1);
        chk("sw0c_lat", 32'(lat), 32'd2);
        do_req(1'b0, 3'b010, 10'h0C, '0, lat, rd, err, mwcnt, mwcyc, va);
        chk("lw0c_data", rd, 32'hDEAD_BEEF);
        chk("lw0c_lat", 32'(lat), 32'd3);

        // invalid codes
        do_req(1'b0, 3'b011, 10'h0C, '0, lat, rd, err, mwcnt, mwcyc, va);
        chk("bad011_err", 32'(err), 32'd1);
        chk("bad011_rdata", rd, 32'd0);
        chk("bad011_lat", 32'(lat), 32'd1);
        chk("bad011_pulse_width", 32'(va), 32'd0);
        do_req(1'b1, 3'b100, 10'h0C, 32'h1234_5678, lat, rd, err, mwcnt, mwcyc, va);
        chk("sbu_err", 32'(err), 32'd1);
        chk("sbu_no_write", 32'(mwcnt), 32'd0);
        chk("sbu_mem", mem[3], 32'hDEAD_BEEF);

        // misaligned word load
        do_req(1'b0, 3'b010, 10'h0E, '0, lat, rd, err, mwcnt, mwcyc, va);
`ifdef LSU_ALIGN_CHECK_EN
        chk("lw0e_err", 32'(err), 32'd1);
        chk("lw0e_rdata", rd, 32'd0);
        chk("lw0e_no_write", 32'(mwcnt), 32'd0);
`else
        chk("lw0e_err", 32'(err), 32'd0);
        chk("lw0e_rdata", rd, 32'hDEAD_BEEF);
`endif

        // reset in WRITE of an SH to mem[1]
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b001;
        bus.req_addr = 10'h04; bus.req_wdata = 32'h0000_7777;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstw_mw_in_write", 32'(mem_mw), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstw_mw_dropped", 32'(mem_mw), 32'd0);
        chk("rstw_ready_in_reset", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rstw_no_rsp", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("rstw_ready_after", 32'(bus.req_ready), 32'd1);
        chk("rstw_mem_unchanged", mem[1], 32'h0000_CAFE);
        do_req(1'b0, 3'b010, 10'h04, '0, lat, rd, err, mwcnt, mwcyc, va);
        chk("rstw_lw_after", rd, 32'h0000_CAFE);
        chk("rstw_lw_lat", 32'(lat), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of the attached data memory.
REQ-002 CLK  input  1  clock, all state updates on rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 REQ_VALID  input  1  request present.
REQ-005 REQ_READY  output  1  unit can accept a request.
REQ-006 REQ_WE  input  1  1 = store, 0 = load.
REQ-007 REQ_FUNCT3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 REQ_ADDR  input  ADDR_W+2  byte address.
REQ-009 REQ_WDATA  input  32  store data, right-justified.
REQ-010 RSP_VALID  output  1  one-cycle completion pulse.
REQ-011 RSP_RDATA  output  32  extended load data, 0 for stores and errors.
REQ-012 RSP_ERR  output  1  request rejected, qualified by RSP_VALID.
REQ-013 MEM_ADDR  output  ADDR_W  word address to data memory.
REQ-014 MEM_DATA  output  32  write word to data memory.
REQ-015 MEM_MW  output  1  memory write enable.
REQ-016 MEM_Q  input  32  memory read word, valid one edge after MEM_ADDR is sampled with MEM_MW=0.

Function
REQ-017 States SHALL be IDLE, READ, MERGE, WRITE, RESP; REQ_READY SHALL be 1 only in IDLE with RST low.
REQ-018 Accept in IDLE when REQ_VALID=1; request fields are registered at that edge.
REQ-019 Load: IDLE->READ (MEM_MW=0, MEM_ADDR=addr[ADDR_W+1:2])->RESP->IDLE; RSP_VALID asserts 3 cycles after the accept edge.
REQ-020 In RESP, RSP_RDATA SHALL be registered from MEM_Q: byte lane addr[1:0], half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged; lanes are little-endian (lane 0 = bits 7:0).
REQ-021 SW: IDLE->WRITE (MEM_MW=1, MEM_DATA=REQ_WDATA)->RESP; no read is issued.
REQ-022 SB/SH: IDLE->READ->MERGE->WRITE->RESP; MERGE registers MEM_Q with the addressed lane(s) replaced by the low 8/16 bits of REQ_WDATA, other lanes preserved.
REQ-023 MEM_MW SHALL be 1 only in WRITE, exactly one cycle per store.
REQ-024 MEM_Q SHALL NOT be sampled in the cycle following a write (memory output undefined).
REQ-025 Invalid code (011, 110, 111; or 100/101 with REQ_WE=1): IDLE->RESP with RSP_ERR=1, no memory access.
REQ-026 RSP_VALID, RSP_ERR SHALL be high for exactly one cycle; RSP_RDATA holds until the next response.
REQ-027 MEM_ADDR, MEM_DATA SHALL be registered and stable across READ/MERGE/WRITE of one request.
REQ-028 REQ_VALID outside IDLE SHALL be ignored; requester holds the request until accepted.

Reset
REQ-029 RST SHALL immediately force IDLE, MEM_MW=0, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, MEM_ADDR=0, MEM_DATA=0.
REQ-030 Reset mid-operation SHALL abandon the request with no response; a write not yet clocked SHALL NOT occur.
REQ-031 First accept SHALL be possible on the first rising edge after RST deasserts.

Configuration
REQ-032 Macro LSU_ALIGN_CHECK_EN defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, SHALL take the REQ-025 error path.
REQ-033 Macro LSU_ALIGN_CHECK_EN undefined: misaligned low bits SHALL be cleared (H: addr[0], W: addr[1:0]) and the access proceed; RSP_ERR asserts only for invalid codes.

Structure
REQ-034 Package lsu_pkg SHALL hold the funct3 constants and the state enumeration.
REQ-035 Sub-module lsu_ld_align (combinational lane select and extension) SHALL implement REQ-020.

Verification
REQ-036 mem[5]=0x8040_20F0; LB addr 0x16 -> RSP_RDATA=0x0000_0040, RSP_VALID 3 cycles after accept.
REQ-037 mem[5]=0x8040_20F0; LH addr 0x16 -> 0xFFFF_8040; LHU addr 0x16 -> 0x0000_8040.
REQ-038 mem[2]=0x1122_3344; SB addr 0x09 data 0xAB -> mem[2]=0x1122_AB44, exactly one MEM_MW pulse, response 4 cycles after accept.
REQ-039 SW addr 0x0C data 0xDEAD_BEEF -> MEM_MW in cycle 1, mem[3]=0xDEAD_BEEF, no read; LW addr 0x0C returns 0xDEAD_BEEF.
REQ-040 With LSU_ALIGN_CHECK_EN: LW addr 0x0E -> RSP_ERR=1, RSP_RDATA=0, MEM_MW never 1; without: returns mem[3].
REQ-041 RST asserted in WRITE state of an SH -> MEM_MW drops asynchronously, memory unchanged, no RSP_VALID, REQ_READY=1 after release.
